// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among N byte-stream requesters.
// One byte in flight at a time; req_ready is held low (stalling the requester) until the UART drains.
module uart_tx_arbiter #(
    parameter int N           = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int STALL_LIMIT = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           uart_wr,
    output logic [7:0]     uart_dat,
    input  logic           uart_tx_busy,
    output logic           busy,
    output logic           err_ack,
    output logic           err_stall,
    input  logic           err_clr
);
    localparam int PW = $clog2(N);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [PW:0]   N_EXT     = (PW + 1)'(N);
    localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);
    localparam logic [AW-1:0] ACK_MAX   = AW'(ACK_TIMEOUT);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  grant_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gidx_q;
    logic          last_q;
    logic [AW-1:0] ack_q;
    logic [SW-1:0] stall_q;
    logic          wr_q;
    logic [7:0]    dat_q;
    logic          busy_q;
    logic          err_ack_q;
    logic          err_stall_q;

    logic          win_vld_d;
    logic [PW-1:0] win_idx_d;
    logic [PW:0]   cand;

    // Scan downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (PW + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (req_valid[cand[PW-1:0]]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand[PW-1:0];
            end
        end
    end

    logic          sel_vld;
    logic          sel_last;
    logic [7:0]    sel_dat;
    logic [PW-1:0] next_ptr;

    always_comb begin
        sel_vld  = |(req_valid & grant_q);
        sel_last = |(req_last & grant_q);
        sel_dat  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                sel_dat = req_data[8*i +: 8];
            end
        end
    end

    assign next_ptr  = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);
    assign req_ready = (state_q == ISSUE) ? (req_valid & grant_q) : '0;
    assign grant     = grant_q;
    assign uart_wr   = wr_q;
    assign uart_dat  = dat_q;
    assign busy      = busy_q;
    assign err_ack   = err_ack_q;
    assign err_stall = err_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            gidx_q      <= '0;
            last_q      <= 1'b0;
            ack_q       <= '0;
            stall_q     <= '0;
            wr_q        <= 1'b0;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            err_ack_q   <= 1'b0;
            err_stall_q <= 1'b0;
        end else begin
            wr_q        <= 1'b0;
            // Clear first; an error set later in this block overrides a same-cycle clear.
            err_ack_q   <= err_ack_q & ~err_clr;
            err_stall_q <= err_stall_q & ~err_clr;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        grant_q <= N'(1) << win_idx_d;
                        gidx_q  <= win_idx_d;
                        stall_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sel_vld) begin
                        dat_q   <= sel_dat;
                        last_q  <= sel_last;
                        wr_q    <= 1'b1;
                        ack_q   <= '0;
                        stall_q <= '0;
                        state_q <= WAIT_ACK;
                    end else if (stall_q == STALL_MAX) begin
                        err_stall_q <= 1'b1;
                        grant_q     <= '0;
                        ptr_q       <= next_ptr;
                        stall_q     <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        stall_q <= stall_q + SW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (uart_tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (ack_q == ACK_MAX) begin
                        err_ack_q <= 1'b1;
                        state_q   <= WAIT_DONE;
                    end else begin
                        ack_q <= ack_q + AW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        if (last_q) begin
                            grant_q <= '0;
                            ptr_q   <= next_ptr;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter: a packet-level round-robin model
// fills a scoreboard of (owner, byte) pairs that a monitor checks on every uart_wr.
module tb_uart_tx_arbiter;
    localparam int N           = 4;
    localparam int ACK_TIMEOUT = 16;
    localparam int STALL_LIMIT = 50;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           uart_wr;
    logic [7:0]     uart_dat;
    logic           uart_tx_busy;
    logic           busy;
    logic           err_ack;
    logic           err_stall;
    logic           err_clr = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .ACK_TIMEOUT(ACK_TIMEOUT), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .grant(grant), .uart_wr(uart_wr), .uart_dat(uart_dat), .uart_tx_busy(uart_tx_busy),
        .busy(busy), .err_ack(err_ack), .err_stall(err_stall), .err_clr(err_clr)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0]  drv_q [N][$];   // {last, data} per requester, consumed by the driver
    logic [8:0]  mdl_q [N][$];   // same bytes, consumed by the reference model
    logic [11:0] exp_q [$];      // {one-hot owner, byte} in expected UART order
    int          mp = 0;         // model round-robin pointer
    bit          uart_ack_en = 1'b1;
    int          uart_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic pb(input int i, input logic [7:0] d, input logic l);
        drv_q[i].push_back({l, d});
        mdl_q[i].push_back({l, d});
    endtask

    task automatic drv_only(input int i, input logic [7:0] d, input logic l);
        drv_q[i].push_back({l, d});
    endtask

    // Whole-packet round robin: each grant drains one packet, next search starts after the owner.
    task automatic plan();
        int g;
        bit any;
        bit more;
        logic [8:0] b;
        more = 1'b1;
        while (more) begin
            any = 1'b0;
            g = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mp + k) % N;
                if (!any && mdl_q[idx].size() > 0) begin
                    any = 1'b1;
                    g = idx;
                end
            end
            if (!any) begin
                more = 1'b0;
            end else begin
                do begin
                    b = mdl_q[g].pop_front();
                    exp_q.push_back({4'(1 << g), b[7:0]});
                end while (!b[8] && mdl_q[g].size() > 0);
                mp = (g + 1) % N;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        do begin
            @(negedge clk);
            n++;
            done = (exp_q.size() == 0) && !busy && !uart_tx_busy;
            for (int i = 0; i < N; i++) begin
                if (drv_q[i].size() > 0) done = 1'b0;
            end
        end while (!done && n < 4000);
        chk({tag, "_drain"}, 32'(done), 1);
    endtask

    task automatic do_reset(input string tag);
        int n;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            mdl_q[i].delete();
        end
        exp_q.delete();
        #1;
        chk({tag, "_rst_grant"}, 32'(grant), 0);
        chk({tag, "_rst_ready"}, 32'(req_ready), 0);
        chk({tag, "_rst_wr"}, 32'(uart_wr), 0);
        chk({tag, "_rst_dat"}, 32'(uart_dat), 0);
        chk({tag, "_rst_busy"}, 32'(busy), 0);
        chk({tag, "_rst_errs"}, {30'd0, err_ack, err_stall}, 0);
        n = 0;
        while (uart_tx_busy && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        mp = 0;
    endtask

    task automatic wait_wr(input string tag);
        int n;
        n = 0;
        while (!uart_wr && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wr_seen"}, 32'(uart_wr), 1);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
    endtask

    // Requester driver: bytes leave the queue only on a valid&ready cycle.
    initial begin
        logic [N-1:0] acc;
        logic [8:0] h;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0) begin
                    h = drv_q[i][0];
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = h[7:0];
                    req_last[i]         = h[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // UART model: busy rises a few cycles after each strobe and holds for a while.
    initial begin
        int d;
        int l;
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && uart_wr && uart_ack_en) begin
                d = (uart_len > 0) ? 1 : $urandom_range(1, 3);
                l = (uart_len > 0) ? uart_len : $urandom_range(1, 4);
                repeat (d) @(posedge clk);
                #1 uart_tx_busy = 1'b1;
                repeat (l) @(posedge clk);
                #1 uart_tx_busy = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pop on every strobe, lock rule on every accept.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_ready != '0) begin
                    chk("ready_locked", 32'($onehot(req_ready) && ((req_ready & ~grant) == '0)), 1);
                end
                if (uart_wr) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got owner %0h byte %0h want none", grant, uart_dat);
                    end else begin
                        e = exp_q.pop_front();
                        chk("uart_byte", 32'(uart_dat), 32'(e[7:0]));
                        chk("uart_owner", 32'(grant), 32'(e[11:8]));
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int cnt;
        #2;
        do_reset("init");

        // Single byte from requester 2 with a long UART busy.
        uart_len = 20;
        pb(2, 8'h5A, 1'b1);
        plan();
        drain("single");
        chk("single_grant_idle", 32'(grant), 0);
        chk("single_busy_idle", 32'(busy), 0);

        // Packet lock: requester 1 waits behind requester 0's 3-byte packet.
        uart_len = 0;
        pb(0, 8'h11, 1'b0);
        pb(0, 8'h22, 1'b0);
        pb(0, 8'h33, 1'b1);
        pb(1, 8'hAA, 1'b1);
        plan();
        drain("lock");

        // Round robin from pointer 0 with everyone pending.
        do_reset("rr");
        pb(0, 8'hA0, 1'b1);
        pb(0, 8'hA0, 1'b1);
        for (int i = 1; i < N; i++) pb(i, 8'(8'hA0 + i), 1'b1);
        plan();
        drain("rr");

        // Ack timeout: UART never answers.
        uart_ack_en = 1'b0;
        pb(1, 8'h3C, 1'b1);
        pb(2, 8'h3D, 1'b1);
        plan();
        wait_wr("ack");
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!err_ack && cnt < 60);
        chk("ack_latency", 32'(cnt), ACK_TIMEOUT + 1);
        drain("ack");
        chk("ack_sticky", 32'(err_ack), 1);
        pulse_clr();
        chk("ack_cleared", 32'(err_ack), 0);
        uart_ack_en = 1'b1;

        // Randomized packet mixes.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) pb(i, 8'($urandom), b == len - 1);
                end
            end
            plan();
            drain("rand");
        end
        chk("rand_no_errs", {30'd0, err_ack, err_stall}, 0);

        // Stall: requester 3 abandons its packet; requester 0 waits its turn.
        do_reset("stall");
        drv_only(3, 8'h5E, 1'b0);
        exp_q.push_back({4'b1000, 8'h5E});
        wait_wr("stall");
        drv_only(0, 8'h77, 1'b1);
        exp_q.push_back({4'b0001, 8'h77});
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 45) chk("stall_not_early", 32'(err_stall), 0);
        end while (!err_stall && cnt < 200);
        chk("stall_flag", 32'(err_stall), 1);
        chk("stall_grant_revoked", 32'(grant), 0);
        drain("stall");
        chk("stall_sticky", 32'(err_stall), 1);
        pulse_clr();
        chk("stall_cleared", 32'(err_stall), 0);

        // Mid-packet reset, then arbitration restarts from pointer 0.
        do_reset("mid_pre");
        pb(2, 8'h20, 1'b1);
        plan();
        drain("mid_adv");
        uart_len = 20;
        drv_only(2, 8'h21, 1'b0);
        drv_only(2, 8'h22, 1'b1);
        exp_q.push_back({4'b0100, 8'h21});
        wait_wr("mid");
        repeat (4) @(negedge clk);
        chk("mid_in_wait_done", {30'd0, busy, uart_tx_busy}, 3);
        #2;
        do_reset("mid");
        uart_len = 0;
        pb(1, 8'h31, 1'b1);
        pb(3, 8'h33, 1'b1);
        plan();
        drain("mid_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N byte-stream requesters.
- Uses round-robin arbitration with packet locking: a grant is held until the requester's last byte has been handed to the UART.
- Sequences the UART's wr/busy handshake one byte at a time.
- Sits between on-chip sources (console, debug, status reporters) and the UART tx_busy/wr_i/dat_i interface.
- Flags a UART that never acknowledges, and a requester that stalls mid-packet.

Parameters:
- N, 4, number of requesters (2..8).
- ACK_TIMEOUT, 16, cycles to wait for uart_tx_busy to rise after a write strobe.
- STALL_LIMIT, 1000000, idle cycles tolerated mid-packet before the grant is revoked.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req_valid  in  N  per-requester byte available.
- req_data  in  8*N  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  N  qualifies the byte as the last of its packet.
- req_ready  out  N  one-hot accept strobe; byte transferred when valid&ready.
- grant  out  N  one-hot owner of the UART; 0 when idle.
- uart_wr  out  1  one-cycle write strobe to the UART.
- uart_dat  out  8  byte to the UART, stable from the strobe until the next strobe.
- uart_tx_busy  in  1  UART transmitter busy.
- busy  out  1  arbiter not in IDLE.
- err_ack  out  1  sticky: UART failed to assert busy within ACK_TIMEOUT.
- err_stall  out  1  sticky: grant revoked after a mid-packet stall.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
  - On reset: state=IDLE; grant=0, req_ready=0, uart_wr=0, uart_dat=0x00, busy=0, err_ack=0, err_stall=0.
  - Round-robin pointer resets to 0. Timers reset to 0.
  - Reset mid-packet abandons the packet; there is no resume.
- All outputs are registered except req_ready, which is the combinational decode of (state==ISSUE & grant & req_valid).
- State machine:
  - IDLE:
    - If any req_valid: pick the first set bit searching upward from pointer p, wrapping modulo N.
    - grant<=onehot(winner); go to ISSUE.
    - If none valid, stay in IDLE.
  - ISSUE:
    - If req_valid[g]: req_ready[g]=1 this cycle; uart_dat<=req_data[g]; last_r<=req_last[g]; uart_wr<=1; clear ack timer; go to WAIT_ACK.
    - Otherwise increment the stall timer. When it reaches STALL_LIMIT: err_stall<=1; grant<=0; p<=g+1; go to IDLE.
    - The stall timer clears on every accepted byte.
  - WAIT_ACK:
    - uart_wr<=0, so the strobe is exactly 1 cycle.
    - If uart_tx_busy: go to WAIT_DONE.
    - Otherwise increment the ack timer. When it reaches ACK_TIMEOUT: err_ack<=1; treat the byte as sent and take the WAIT_DONE exit.
  - WAIT_DONE, when uart_tx_busy==0:
    - If last_r: grant<=0; p<=(g+1) mod N; go to IDLE.
    - Otherwise go to ISSUE, keeping the same grant.
- Lock rule: while the grant is held, other requesters' req_ready stays 0 regardless of their valid.
- Fairness: after a packet ends, the next search starts at g+1. A single persistent requester is re-granted when it is alone.
- Throughput: at least 4 cycles of arbiter overhead per byte beyond the UART busy time. A granted requester holding valid continuously never triggers a stall.
- Simultaneous events:
  - err_clr has priority below a same-cycle error set; the error wins.
  - A req_valid change on an ungranted port has no effect until IDLE.
- Single-byte packet: req_last=1 on the first byte; the packet releases after that byte's WAIT_DONE.
- Wrap-around: the pointer wraps from N-1 to 0. Timers saturate at their limits and never wrap.

Test Plan:
- Single byte: after reset, requester 2 drives valid=1, data=0x5A, last=1 with the UART model asserting busy 1 cycle after wr for 20 cycles.
  - Required: grant=0100; req_ready[2] pulses once; one uart_wr pulse with uart_dat=0x5A.
  - Required: grant returns to 0 after busy falls; busy=0.
- Packet lock: requester 0 sends a 3-byte packet {0x11,0x22,0x33(last)} while requester 1 holds valid with 0xAA.
  - Required: the UART sees 0x11,0x22,0x33,0xAA in that order.
  - Required: req_ready[1] stays 0 until grant[0] drops.
- Round-robin: all 4 requesters hold single-byte packets continuously (data = 0xA0+i).
  - Required: grant order is 0,1,2,3,0; the UART sees A0,A1,A2,A3,A0.
- Ack timeout: the UART model never asserts busy.
  - Required: err_ack=1 exactly ACK_TIMEOUT+1 cycles after the uart_wr pulse.
  - Required: the arbiter continues with the next byte; err_clr clears err_ack.
- Stall: with STALL_LIMIT=50, requester 3 sends a non-last byte and then drops valid.
  - Required: after 50 cycles in ISSUE, err_stall=1 and grant=0.
  - Required: a pending requester 0 is granted next.
- Mid-packet reset: assert rst during WAIT_DONE.
  - Required: all outputs return to reset values immediately.
  - Required: after release, arbitration starts at pointer 0.
